// File: rtl/fifo_burst_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_checker_pkg
// Purpose  : Shared constants for the FIFO burst checker: FSM state encoding
//            and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_burst_checker_pkg;

  // Five states do not fit in two bits, so the state vector is three bits wide.
  localparam int unsigned c_st_w = 3;

  localparam logic [c_st_w-1:0] c_st_idle   = 3'd0;
  localparam logic [c_st_w-1:0] c_st_arm    = 3'd1;
  localparam logic [c_st_w-1:0] c_st_settle = 3'd2;
  localparam logic [c_st_w-1:0] c_st_read   = 3'd3;
  localparam logic [c_st_w-1:0] c_st_flush  = 3'd4;

  localparam int unsigned c_data_w_def     = 8;
  localparam int unsigned c_rd_latency_def = 1;
  localparam int unsigned c_settle_cyc_def = 10;
  localparam int unsigned c_cnt_w_def      = 16;

endpackage : fifo_burst_checker_pkg
`default_nettype wire

// File: rtl/fifo_rd_vpipe.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_vpipe
// Purpose  : RD_LATENCY-deep delay line for the read-valid bit. Collapses to a
//            wire when RD_LATENCY is 0 (first-word-fall-through FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_vpipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  output logic o_vld,
  output logic o_busy
);

  generate
    if (RD_LATENCY == 0) begin : g_passthru
      // Clock and reset are not needed when data arrives with rd_en.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign o_vld  = i_vld;
      assign o_busy = 1'b0;
    end else begin : g_delay
      logic [RD_LATENCY-1:0] r_sr;

      // Shift the issued-read marker along until the data is on fifo_rdata.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else begin
          r_sr <= (r_sr << 1) | RD_LATENCY'(i_vld);
        end
      end

      assign o_vld  = r_sr[RD_LATENCY-1];
      assign o_busy = |r_sr;
    end
  endgenerate

endmodule : fifo_rd_vpipe
`default_nettype wire

// File: rtl/fifo_burst_checker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_checker
// Purpose  : Waits for the FIFO to reach almost_full, drains it in one burst,
//            and checks every word against an incrementing pattern. Reports the
//            burst word count, a saturating error count and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_checker
  import fifo_burst_checker_pkg::*;
#(
  parameter int unsigned DATA_W     = c_data_w_def,
  parameter int unsigned RD_LATENCY = c_rd_latency_def,
  parameter int unsigned SETTLE_CYC = c_settle_cyc_def,
  parameter int unsigned CNT_W      = c_cnt_w_def
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              chk_en,
  input  logic              almost_full,
  input  logic              almost_empty,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic              busy,
  output logic              rd_done,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              ae_seen
);

  localparam int unsigned c_set_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [c_st_w-1:0]  r_state;
  logic [c_st_w-1:0]  w_state_nxt;
  logic [c_set_w-1:0] r_settle_cnt;
  logic               w_settle_done;
  logic               w_start;
  logic               w_rd_en;
  logic               w_vld;
  logic               w_pipe_busy;
  logic               w_in_burst;
  logic [DATA_W-1:0]  r_exp;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_flag;
  logic               r_ae_seen;

  assign w_settle_done = (r_settle_cnt == c_set_w'(SETTLE_CYC - 1));

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; chk_en only matters before the settle phase starts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (chk_en) w_state_nxt = c_st_arm;
      c_st_arm: begin
        if (!chk_en) begin
          w_state_nxt = c_st_idle;
        end else if (almost_full) begin
          w_state_nxt = c_st_settle;
        end
      end
      c_st_settle: if (w_settle_done) w_state_nxt = c_st_read;
      c_st_read:   if (empty) w_state_nxt = c_st_flush;
      c_st_flush:  if (!w_pipe_busy) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // State-decoded outputs; rd_en is gated by empty so an empty FIFO is never read.
  always_comb begin
    w_rd_en    = (r_state == c_st_read) && !empty;
    busy       = (r_state != c_st_idle);
    rd_done    = (r_state == c_st_flush) && !w_pipe_busy;
    w_start    = (r_state == c_st_settle) && w_settle_done;
    w_in_burst = (r_state == c_st_read) || (r_state == c_st_flush);
    fifo_rd_en = w_rd_en;
  end

  // Count settle cycles; held at zero outside SETTLE so every burst waits in full.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_settle_cnt <= '0;
    end else if (r_state != c_st_settle) begin
      r_settle_cnt <= '0;
    end else if (!w_settle_done) begin
      r_settle_cnt <= r_settle_cnt + c_set_w'(1);
    end
  end

  fifo_rd_vpipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_vpipe (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .i_vld  (w_rd_en),
    .o_vld  (w_vld),
    .o_busy (w_pipe_busy)
  );

  // Pattern checker: exp advances on every valid word so one bad word costs one count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_exp      <= '0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
      r_ae_seen  <= 1'b0;
    end else if (w_start) begin
      r_exp      <= '0;
      r_word_cnt <= '0;
      r_ae_seen  <= 1'b0;
    end else begin
      if (w_vld) begin
        r_exp <= r_exp + DATA_W'(1);
        if (r_word_cnt != '1) begin
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
        if (fifo_rdata != r_exp) begin
          r_err_flag <= 1'b1;
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
        end
      end
      if (w_in_burst && almost_empty) begin
        r_ae_seen <= 1'b1;
      end
    end
  end

  assign word_cnt = r_word_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_flag = r_err_flag;
  assign ae_seen  = r_ae_seen;

endmodule : fifo_burst_checker
`default_nettype wire
